// File: rtl/npc_predict_if.sv
// Fetch/decode bus of the next-PC generator: fetch PC and prediction out,
// branch/jump resolution from decode in.
interface npc_predict_if;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [1:0]  res_op;
  logic [31:0] res_pc;
  logic        res_cond;
  logic [15:0] res_imm16;
  logic [25:0] res_imm26;
  logic [31:0] res_reg;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        redirect;

  modport master (
    output stall, res_valid, res_op, res_pc, res_cond, res_imm16, res_imm26,
           res_reg, res_pred_taken, res_pred_target,
    input  pc, pc4, pred_taken, pred_target, redirect
  );

  modport slave (
    input  stall, res_valid, res_op, res_pc, res_cond, res_imm16, res_imm26,
           res_reg, res_pred_taken, res_pred_target,
    output pc, pc4, pred_taken, pred_target, redirect
  );
endinterface

// File: rtl/npc_predict.sv
// Fetch-stage PC register with a direct-mapped 2-bit-counter BTB predictor.
// The BTB exists only when NPC_BTB_EN is defined; otherwise it always predicts pc+4.
module npc_predict #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          BTB_ENTRIES = 8,
  localparam int         IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  npc_predict_if.slave  bus
);

  if (BTB_ENTRIES < 2 || BTB_ENTRIES > 64 || (2 ** IDX_W) != BTB_ENTRIES) begin : g_bad_cfg
    $error("npc_predict: BTB_ENTRIES must be a power of two in 2..64");
  end

  logic [31:0] pc_r;
  logic [31:0] pc4_s;
  logic        pred_taken_s;
  logic [31:0] pred_target_s;
  logic [31:0] seq_s;
  logic [31:0] br_tgt_s;
  logic [31:0] act_tgt_s;
  logic        act_taken_s;
  logic        redirect_s;
  logic [31:0] next_pc_s;

  assign pc4_s    = pc_r + 32'd4;
  assign seq_s    = bus.res_pc + 32'd4;
  assign br_tgt_s = seq_s + {{14{bus.res_imm16[15]}}, bus.res_imm16, 2'b00};

  // Actual outcome of the resolving instruction
  always_comb begin
    act_taken_s = 1'b0;
    act_tgt_s   = seq_s;
    case (bus.res_op)
      2'b00: begin
        act_taken_s = 1'b0;
        act_tgt_s   = seq_s;
      end
      2'b01: begin
        act_taken_s = bus.res_cond;
        act_tgt_s   = br_tgt_s;
      end
      2'b10: begin
        act_taken_s = 1'b1;
        act_tgt_s   = {bus.res_pc[31:28], bus.res_imm26, 2'b00};
      end
      2'b11: begin
        act_taken_s = 1'b1;
        act_tgt_s   = bus.res_reg;
      end
      default: begin
        act_taken_s = 1'b0;
        act_tgt_s   = seq_s;
      end
    endcase
  end

  // Held low during reset so a stale decode entry cannot flush the pipe.
  assign redirect_s = reset & bus.res_valid &
                      ((act_taken_s != bus.res_pred_taken) |
                       (act_taken_s & (act_tgt_s != bus.res_pred_target)));

  // Next-PC selection: redirect overrides stall, stall overrides prediction
  always_comb begin
    next_pc_s = pred_target_s;
    if (redirect_s) begin
      next_pc_s = act_taken_s ? act_tgt_s : seq_s;
    end else if (bus.stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pred_target_s;
    end
  end

  // Architectural fetch PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

`ifdef NPC_BTB_EN
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]       tag_r [BTB_ENTRIES];
  logic [31:0]            tgt_r [BTB_ENTRIES];
  logic [1:0]             cnt_r [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             upd_s;
  logic             wr_en_s;
  logic [1:0]       wr_cnt_s;
  logic [31:0]      wr_tgt_s;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    if (up) begin
      r = (c == 2'd3) ? 2'd3 : c + 2'd1;
    end else begin
      r = (c == 2'd0) ? 2'd0 : c - 2'd1;
    end
    return r;
  endfunction

  assign lk_idx_s      = pc_r[IDX_W+1:2];
  assign lk_tag_s      = pc_r[31:IDX_W+2];
  assign lk_hit_s      = valid_r[lk_idx_s] & (tag_r[lk_idx_s] == lk_tag_s);
  assign pred_taken_s  = lk_hit_s & cnt_r[lk_idx_s][1];
  assign pred_target_s = pred_taken_s ? tgt_r[lk_idx_s] : pc4_s;

  assign up_idx_s = bus.res_pc[IDX_W+1:2];
  assign up_tag_s = bus.res_pc[31:IDX_W+2];
  assign up_hit_s = valid_r[up_idx_s] & (tag_r[up_idx_s] == up_tag_s);
  assign upd_s    = bus.res_valid & (bus.res_op != 2'b00);

  // BTB write decision: train on a hit, allocate only on a taken miss
  always_comb begin
    wr_en_s  = 1'b0;
    wr_cnt_s = cnt_r[up_idx_s];
    wr_tgt_s = tgt_r[up_idx_s];
    if (upd_s && up_hit_s) begin
      wr_en_s  = 1'b1;
      wr_cnt_s = sat_step(cnt_r[up_idx_s], act_taken_s);
      wr_tgt_s = act_taken_s ? act_tgt_s : tgt_r[up_idx_s];
    end else if (upd_s && act_taken_s) begin
      wr_en_s  = 1'b1;
      wr_cnt_s = (bus.res_op == 2'b01) ? 2'd2 : 2'd3;
      wr_tgt_s = act_tgt_s;
    end else begin
      wr_en_s  = 1'b0;
    end
  end

  // Valid bits are the only BTB state that needs clearing on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
    end else if (wr_en_s) begin
      valid_r[up_idx_s] <= 1'b1;
    end
  end

  // BTB payload storage
  always_ff @(posedge clk) begin
    if (reset && wr_en_s) begin
      tag_r[up_idx_s] <= up_tag_s;
      tgt_r[up_idx_s] <= wr_tgt_s;
      cnt_r[up_idx_s] <= wr_cnt_s;
    end
  end
`else
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = pc4_s;
`endif

  assign bus.pc          = pc_r;
  assign bus.pc4         = pc4_s;
  assign bus.pred_taken  = pred_taken_s;
  assign bus.pred_target = pred_target_s;
  assign bus.redirect    = redirect_s;

endmodule

// File: tb/tb_npc_predict.sv
// Bench for npc_predict: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the predictor.
module tb_npc_predict;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npc_predict_if bus ();

  npc_predict #(.RESET_PC(32'h0000_3000), .BTB_ENTRIES(N)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_pc;
`ifdef NPC_BTB_EN
  localparam bit BTB = 1'b1;
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tg  [N];
  int          m_cnt [N];
`else
  localparam bit BTB = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
  endtask

  function automatic void m_reset();
    m_pc = 32'h0000_3000;
`ifdef NPC_BTB_EN
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
`endif
  endfunction

  function automatic void m_predict(input logic [31:0] p, output bit t, output logic [31:0] tg);
    t  = 1'b0;
    tg = p + 32'd4;
`ifdef NPC_BTB_EN
    begin
      int i = int'((p / 4) % N);
      if (m_v[i] && m_tag[i] == p / (4 * N) && m_cnt[i] >= 2) begin
        t  = 1'b1;
        tg = m_tg[i];
      end
    end
`endif
  endfunction

  function automatic void m_outcome(output bit t, output logic [31:0] tg);
    int off;
    off = int'($signed(bus.res_imm16));
    t   = 1'b0;
    tg  = bus.res_pc + 32'd4;
    case (bus.res_op)
      2'd1: begin t = bus.res_cond; tg = bus.res_pc + 32'd4 + 32'(off * 4); end
      2'd2: begin t = 1'b1; tg = (bus.res_pc & 32'hF000_0000) | (32'(bus.res_imm26) * 32'd4); end
      2'd3: begin t = 1'b1; tg = bus.res_reg; end
      default: begin t = 1'b0; end
    endcase
  endfunction

  function automatic bit m_redirect();
    bit t; logic [31:0] tg;
    m_outcome(t, tg);
    return bus.res_valid && (t != bus.res_pred_taken || (t && tg != bus.res_pred_target));
  endfunction

  // Apply one rising edge to the model (uses pre-edge inputs and state)
  function automatic void m_step();
    bit pt, t, rd; logic [31:0] ptg, tg;
    m_predict(m_pc, pt, ptg);
    m_outcome(t, tg);
    rd = m_redirect();
`ifdef NPC_BTB_EN
    if (bus.res_valid && bus.res_op != 2'd0) begin
      int i = int'((bus.res_pc / 4) % N);
      bit h = m_v[i] && m_tag[i] == bus.res_pc / (4 * N);
      if (h) begin
        if (t) begin m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1; m_tg[i] = tg; end
        else   m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end else if (t) begin
        m_v[i] = 1'b1; m_tag[i] = bus.res_pc / (4 * N); m_tg[i] = tg;
        m_cnt[i] = (bus.res_op == 2'd1) ? 2 : 3;
      end
    end
`endif
    if (rd) m_pc = t ? tg : bus.res_pc + 32'd4;
    else if (bus.stall) m_pc = m_pc;
    else m_pc = ptg;
  endfunction

  task automatic settle_check();
    bit pt; logic [31:0] ptg;
    #1;
    m_predict(m_pc, pt, ptg);
    chk("pc", bus.pc, m_pc);
    chk("pc4", bus.pc4, m_pc + 32'd4);
    chk("pred_taken", 32'(bus.pred_taken), 32'(pt));
    chk("pred_target", bus.pred_target, ptg);
    chk("redirect", 32'(bus.redirect), 32'(m_redirect()));
  endtask

  task automatic advance();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic drive(input bit st, input bit rv, input logic [1:0] op, input logic [31:0] rpc,
                       input bit cond, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rreg, input bit rpt, input logic [31:0] rptg);
    bus.stall = st; bus.res_valid = rv; bus.res_op = op; bus.res_pc = rpc;
    bus.res_cond = cond; bus.res_imm16 = i16; bus.res_imm26 = i26; bus.res_reg = rreg;
    bus.res_pred_taken = rpt; bus.res_pred_target = rptg;
  endtask

  task automatic idle(input bit st);
    drive(st, 1'b0, 2'd0, 32'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0, 32'd0);
  endtask

  typedef struct {
    bit          st; bit rv; logic [1:0] op; logic [31:0] rpc; logic [25:0] i26;
    logic [31:0] e_pc; bit e_pt; logic [31:0] e_ptg; bit e_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3000, 1'b0, 32'h3004, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3004, 1'b0, 32'h3008, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3008, 1'b0, 32'h300C, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 2'd0, 32'h0,    26'h0,       32'h300C, 1'b0, 32'h3010, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3010, 1'b0, 32'h3014, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3010, 1'b0, 32'h3014, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3010, 1'b0, 32'h3014, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 2'd2, 32'h300C, 26'h0000C10, 32'h3010, 1'b0, 32'h3014, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 2'd0, 32'h0,    26'h0,       32'h3040, 1'b0, 32'h3044, 1'b0};

    m_reset();
    idle(1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, 32'h3000);
    reset = 1'b1;

    // Reset stepping, stall hold, and jump overriding stall
    foreach (tbl[k]) begin
      drive(tbl[k].st, tbl[k].rv, tbl[k].op, tbl[k].rpc, 1'b0, 16'd0, tbl[k].i26,
            32'd0, 1'b0, 32'd0);
      #1;
      chk($sformatf("tbl%0d_pc", k), bus.pc, tbl[k].e_pc);
      chk($sformatf("tbl%0d_pc4", k), bus.pc4, tbl[k].e_pc + 32'd4);
      chk($sformatf("tbl%0d_ptaken", k), 32'(bus.pred_taken), 32'(tbl[k].e_pt));
      chk($sformatf("tbl%0d_ptarget", k), bus.pred_target, tbl[k].e_ptg);
      chk($sformatf("tbl%0d_redirect", k), 32'(bus.redirect), 32'(tbl[k].e_rd));
      advance();
    end

    // beq to itself: allocate, then train down with two not-taken outcomes
    drive(1'b0, 1'b1, 2'd1, 32'h3020, 1'b1, 16'hFFFF, 26'd0, 32'd0, 1'b0, 32'h3024);
    settle_check(); chk("beq_redirect", 32'(bus.redirect), 32'd1); advance();
    idle(1'b1);
    settle_check();
    chk("beq_pc", bus.pc, 32'h3020);
    chk("beq_pred_taken", 32'(bus.pred_taken), BTB ? 32'd1 : 32'd0);
    chk("beq_pred_target", bus.pred_target, BTB ? 32'h3020 : 32'h3024);
    advance();
    drive(1'b1, 1'b1, 2'd1, 32'h3020, 1'b0, 16'hFFFF, 26'd0, 32'd0, 1'b1, 32'h3020);
    settle_check(); chk("nt1_redirect", 32'(bus.redirect), 32'd1); advance();
    chk("nt1_pc", bus.pc, 32'h3024);
    drive(1'b1, 1'b1, 2'd1, 32'h3020, 1'b0, 16'hFFFF, 26'd0, 32'd0, 1'b0, 32'h3024);
    settle_check(); chk("nt2_redirect", 32'(bus.redirect), 32'd0); advance();
    drive(1'b0, 1'b1, 2'd3, 32'h3500, 1'b0, 16'd0, 26'd0, 32'h3020, 1'b0, 32'h3504);
    settle_check(); advance();
    idle(1'b1);
    settle_check(); chk("nt2_pred_taken", 32'(bus.pred_taken), 32'd0);
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 1'b1, 2'd1, 32'h3020, 1'b1, 16'hFFFF, 26'd0, 32'd0, 1'b0, 32'h3024);
      settle_check(); chk($sformatf("rep%0d_redirect", r), 32'(bus.redirect), 32'd1); advance();
      idle(1'b1);
      settle_check();
      chk($sformatf("rep%0d_pred_taken", r), 32'(bus.pred_taken),
          (BTB && r == 1) ? 32'd1 : 32'd0);
    end

    // jr target change from the same pc retargets the entry
    drive(1'b0, 1'b1, 2'd3, 32'h3060, 1'b0, 16'd0, 26'd0, 32'h3200, 1'b0, 32'h3064);
    settle_check(); advance();
    drive(1'b0, 1'b1, 2'd3, 32'h3060, 1'b0, 16'd0, 26'd0, 32'h3100, 1'b1, 32'h3200);
    settle_check(); chk("jr_redirect", 32'(bus.redirect), 32'd1); advance();
    chk("jr_pc", bus.pc, 32'h3100);
    drive(1'b0, 1'b1, 2'd2, 32'h3004, 1'b0, 16'd0, 26'h0000C18, 32'd0, 1'b0, 32'h3008);
    settle_check(); advance();
    idle(1'b1);
    settle_check();
    chk("jr_pc2", bus.pc, 32'h3060);
    chk("jr_btb_target", bus.pred_target, BTB ? 32'h3100 : 32'h3064);

    // pc+4 wraps past the top of the address space
    drive(1'b0, 1'b1, 2'd3, 32'h3080, 1'b0, 16'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 32'h3084);
    settle_check(); advance();
    idle(1'b0);
    settle_check(); chk("wrap_pc4", bus.pc4, 32'h0); advance();
    chk("wrap_pc", bus.pc, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      bit pt, t; logic [31:0] ptg, tg;
      logic [31:0] rpc;
      int sel;
      rpc = ($urandom_range(0, 15) == 0) ? $urandom : 32'h3000 + 32'(4 * $urandom_range(0, 23));
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
            rpc, 1'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                           : 16'($urandom_range(0, 16) - 8),
            26'h0000C00 + 26'($urandom_range(0, 40)),
            ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'(4 * $urandom_range(0, 40)),
            1'b0, 32'd0);
      sel = $urandom_range(0, 3);
      m_predict(rpc, pt, ptg);
      m_outcome(t, tg);
      if (sel < 2) begin bus.res_pred_taken = pt; bus.res_pred_target = ptg; end
      else if (sel == 2) begin bus.res_pred_taken = t; bus.res_pred_target = t ? tg : rpc + 32'd4; end
      else begin bus.res_pred_taken = 1'($urandom); bus.res_pred_target = $urandom; end
      settle_check();
      advance();
    end

    // Asynchronous reset in the middle of a pending jump
    drive(1'b0, 1'b1, 2'd2, 32'h3010, 1'b0, 16'd0, 26'h0000D00, 32'd0, 1'b0, 32'h3014);
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    chk("mid_reset_pc", bus.pc, 32'h3000);
    chk("mid_reset_ptaken", 32'(bus.pred_taken), 32'd0);
    chk("mid_reset_ptarget", bus.pred_target, 32'h3004);
    chk("mid_reset_redirect", 32'(bus.redirect), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", bus.pc, 32'h3000);
    idle(1'b0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle_check();
      chk($sformatf("post_reset_pc%0d", c), bus.pc, 32'h3000 + 32'(4 * c));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/npc_predict.md
Name: npc_predict

Overview:
- Fetch-stage next-PC generator for the pipelined MIPS core; successor to the single-cycle combinational next-PC selector.
- Holds the architectural PC register and predicts the next PC with a parametrised direct-mapped branch target buffer (BTB) using 2-bit counters.
- Accepts branch/jump resolution from the decode stage, recomputes the true next PC (beq / j / jal / jr), and raises a redirect on mispredict.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- BTB_ENTRIES, 8, number of BTB entries; power of two, range 2..64.
- IDX_W, log2(BTB_ENTRIES), derived index width; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freeze PC (hazard unit).
- pc  out  32  current fetch PC.
- pc4  out  32  pc + 4.
- pred_taken  out  1  prediction made for the current pc; carried down the pipe.
- pred_target  out  32  predicted next PC for the current pc; carried down the pipe.
- res_valid  in  1  decode stage holds a resolvable instruction this cycle.
- res_op  in  2  00 sequential, 01 conditional branch, 10 j/jal imm26, 11 jr.
- res_pc  in  32  PC of the resolving instruction.
- res_cond  in  1  branch condition result (op 01 only).
- res_imm16  in  16  branch offset.
- res_imm26  in  26  jump index.
- res_reg  in  32  jr register value.
- res_pred_taken  in  1  pred_taken that was returned with res_pc.
- res_pred_target  in  32  pred_target that was returned with res_pc.
- redirect  out  1  combinational; mispredict this cycle, flush younger stages.

Behaviour:
- Reset (async, reset==0): pc=RESET_PC; all BTB valid bits=0. This forces pred_taken=0, pred_target=RESET_PC+4 and redirect=0 while reset is held. Reset mid-operation discards all in-flight BTB updates.
- Actual outcome (combinational):
  - op 00: taken=0.
  - op 01: taken=res_cond; target=res_pc+4+{sext(imm16),2'b00}.
  - op 10: taken=1; target={res_pc[31:28],imm26,2'b00}.
  - op 11: taken=1; target=res_reg, with no alignment check.
  - Not-taken next PC = res_pc+4.
- redirect = res_valid & (taken != res_pred_taken | (taken & target != res_pred_target)).
- Next pc at the rising edge, in priority order:
  - redirect: taken ? target : res_pc+4. Stall is ignored.
  - stall: hold.
  - otherwise: pred_target.
- Prediction (combinational on pc):
  - Lookup: idx=pc[IDX_W+1:2], tag=pc[31:IDX_W+2].
  - hit = valid & tag match.
  - pred_taken = hit & cnt[1].
  - pred_target = pred_taken ? btb_target : pc+4.
- BTB update at the rising edge when res_valid & res_op!=00, independent of stall, using res_pc's index and tag:
  - Hit: counter +1 if taken, −1 if not, saturating 0..3. Target overwritten if taken.
  - Miss & taken: allocate with valid=1, tag, target. Counter=2 for op 01, 3 for ops 10/11.
  - Miss & not taken: no change.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents. The write is visible the next cycle.
- Address arithmetic is mod 2^32; pc+4 wraps from 32'hFFFF_FFFC to 0.
- Latency: redirect is asserted in the cycle of resolution, and the corrected pc appears one edge later.

Optional Feature:
- Macro NPC_BTB_EN.
- Defined: BTB, counters and prediction exactly as above.
- Undefined: no BTB storage; pred_taken=0 and pred_target=pc+4 always. Every taken branch or jump raises redirect. Port list is unchanged.

Test Plan:
- Reset with reset=0 mid-run: pc=32'h3000 asynchronously. After release and no res_valid, pc steps 3004, 3008, ... each cycle.
- stall=1 for 3 cycles at pc=32'h3010: pc holds 3010. Then with res_valid & op 10, res_pc=300C, imm26=26'h0000C10, pc becomes 32'h3040 despite stall.
- beq at res_pc=3020, imm16=16'hFFFF, cond=1, pred 0: redirect=1 and pc becomes 3020. Entry is allocated with cnt=2. On the next fetch of 3020, pred_taken=1 and pred_target=3020.
- Same beq resolves not-taken twice: counter goes 2→1→0 and pred_taken drops to 0. A mispredicted pred (taken, 3020) raises redirect to 3024.
- jr with res_reg=32'h0000_3100 after an earlier jr to 3200 from the same pc: redirect fires on the target mismatch and the BTB target updates to 3100.
- Build without NPC_BTB_EN and repeat the third scenario twice: redirect=1 both times and pred_taken stays 0.
